// File: rtl/tmp_bitstream_decimator.sv
// Decimates the sensor phase-controller charge-steering bitstream over a fixed
// sample window into an offset-binary temperature code with a valid/ack handshake.
module tmp_bitstream_decimator #(
    parameter int unsigned N_SAMPLES = 64,
    parameter int unsigned SETTLE_N  = 30,
    parameter int unsigned CODE_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              smp,
    input  logic              src_n,
    input  logic              snk,
    input  logic              code_ack,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    output logic              busy,
    output logic              ovr,
    output logic              conflict
);

    localparam int unsigned ACC_W  = $clog2(N_SAMPLES) + 2;
    localparam int unsigned CNT_W  = $clog2(N_SAMPLES + 1);
    localparam int unsigned SCNT_W = (SETTLE_N > 0) ? $clog2(SETTLE_N + 1) : 1;

    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'((SETTLE_N > 0) ? SETTLE_N - 1 : 0);
    localparam logic [CNT_W-1:0]  N_LAST    = CNT_W'(N_SAMPLES - 1);
    localparam logic [CODE_W-1:0] CODE_MID  = CODE_W'(N_SAMPLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2
    } state_t;

    state_t                   state;
    logic [SCNT_W-1:0]        scnt;
    logic [CNT_W-1:0]         n;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     win_done;
    logic                     is_conflict;
    logic [CODE_W-1:0]        result;

    // Per-sample accumulator step; a simultaneous source+sink request contributes nothing.
    always_comb begin
        acc_next = acc;
        if (!src_n && !snk) begin
            acc_next = acc + ACC_W'(1);
        end else if (src_n && snk) begin
            acc_next = acc - ACC_W'(1);
        end
    end

    assign is_conflict = !src_n && snk;
    assign win_done    = (state == ACCUM) && en && smp && (n == N_LAST);
    // acc_next is sign-extended (or wrapped) into the code width; the true sum is always in range.
    assign result      = CODE_MID + CODE_W'(acc_next);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            scnt       <= '0;
            n          <= '0;
            acc        <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            ovr        <= 1'b0;
            conflict   <= 1'b0;
        end else begin
            // Result handshake: a same-cycle ack frees the slot for the new result.
            if (win_done) begin
                if (!code_valid || code_ack) begin
                    code       <= result;
                    code_valid <= 1'b1;
                end else begin
                    ovr <= 1'b1;
                end
            end else if (code_valid && code_ack) begin
                code_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        state <= (SETTLE_N == 0) ? ACCUM : SETTLE;
                        busy  <= 1'b1;
                        scnt  <= '0;
                        acc   <= '0;
                        n     <= '0;
                    end
                end
                SETTLE: begin
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (smp) begin
                        if (scnt == SCNT_LAST) begin
                            state <= ACCUM;
                            acc   <= '0;
                            n     <= '0;
                        end else begin
                            scnt <= scnt + SCNT_W'(1);
                        end
                    end
                end
                ACCUM: begin
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (smp) begin
                        if (is_conflict) begin
                            conflict <= 1'b1;
                        end
                        if (n == N_LAST) begin
                            acc <= '0;
                            n   <= '0;
                        end else begin
                            acc <= acc_next;
                            n   <= n + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmp_bitstream_decimator.sv
// Self-checking bench for tmp_bitstream_decimator (N_SAMPLES=8, SETTLE_N=2, CODE_W=5).
module tb_tmp_bitstream_decimator;

    localparam int unsigned N_SAMPLES = 8;
    localparam int unsigned SETTLE_N  = 2;
    localparam int unsigned CODE_W    = 5;

    logic              clk;
    logic              reset;
    logic              en;
    logic              smp;
    logic              src_n;
    logic              snk;
    logic              code_ack;
    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              busy;
    logic              ovr;
    logic              conflict;

    logic auto_ack;
    logic manual_ack;
    int   checks;
    int   failures;
    int   exp_q[$];

    // Sample kinds: 0 idle, 1 source (+1), 2 sink (-1), 3 conflict (0).
    typedef struct {
        logic [15:0] pat;
        int          gap;
        int          exp_code;
        logic        exp_conf;
    } vec_t;

    vec_t vecs[9];

    tmp_bitstream_decimator #(
        .N_SAMPLES(N_SAMPLES),
        .SETTLE_N (SETTLE_N),
        .CODE_W   (CODE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .smp       (smp),
        .src_n     (src_n),
        .snk       (snk),
        .code_ack  (code_ack),
        .code      (code),
        .code_valid(code_valid),
        .busy      (busy),
        .ovr       (ovr),
        .conflict  (conflict)
    );

    assign code_ack = auto_ack ? code_valid : manual_ack;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input logic [1:0] kind, input int gap);
        smp = 1'b1;
        case (kind)
            2'd0: begin src_n = 1'b1; snk = 1'b0; end
            2'd1: begin src_n = 1'b0; snk = 1'b0; end
            2'd2: begin src_n = 1'b1; snk = 1'b1; end
            default: begin src_n = 1'b0; snk = 1'b1; end
        endcase
        tick();
        smp   = 1'b0;
        src_n = 1'b1;
        snk   = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic drive_window(input logic [15:0] pat, input int gap);
        for (int i = 0; i < 8; i++) begin
            drive_sample(pat[2*i +: 2], gap);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_code"}, int'(code), 0);
        chk({tag, "_valid"}, int'(code_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_ovr"}, int'(ovr), 0);
        chk({tag, "_conflict"}, int'(conflict), 0);
    endtask

    // Scoreboard: each accepted result is compared with the oldest expected code.
    always @(negedge clk) begin
        if (auto_ack && code_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_result", int'(code), -1);
            end else begin
                chk("sb_code", int'(code), exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        en         = 1'b0;
        smp        = 1'b0;
        src_n      = 1'b1;
        snk        = 1'b0;
        auto_ack   = 1'b0;
        manual_ack = 1'b0;

        vecs[0] = '{pat: 16'h5555, gap: 0, exp_code: 16, exp_conf: 1'b0};
        vecs[1] = '{pat: 16'h9999, gap: 0, exp_code: 8,  exp_conf: 1'b0};
        vecs[2] = '{pat: 16'hA555, gap: 0, exp_code: 12, exp_conf: 1'b0};
        vecs[3] = '{pat: 16'hAAAA, gap: 0, exp_code: 0,  exp_conf: 1'b0};
        vecs[4] = '{pat: 16'h5555, gap: 2, exp_code: 16, exp_conf: 1'b0};
        vecs[5] = '{pat: 16'h0000, gap: 1, exp_code: 8,  exp_conf: 1'b0};
        vecs[6] = '{pat: 16'h0015, gap: 0, exp_code: 11, exp_conf: 1'b0};
        vecs[7] = '{pat: 16'h0002, gap: 0, exp_code: 7,  exp_conf: 1'b0};
        vecs[8] = '{pat: 16'hD555, gap: 0, exp_code: 15, exp_conf: 1'b1};

        // Reset state
        #12;
        check_outputs_zero("reset");
        tick();
        reset = 1'b0;
        tick();

        // First conversion: latency and settle discard
        en = 1'b1;
        tick();
        chk("enable_busy", int'(busy), 1);
        drive_sample(2'd1, 0);
        drive_sample(2'd1, 0);
        for (int i = 0; i < 7; i++) drive_sample(2'd1, 0);
        chk("first_pre_valid", int'(code_valid), 0);
        chk("first_busy", int'(busy), 1);
        drive_sample(2'd1, 0);
        chk("first_valid", int'(code_valid), 1);
        chk("first_code", int'(code), 16);
        tick();
        chk("first_hold_valid", int'(code_valid), 1);
        manual_ack = 1'b1;
        tick();
        manual_ack = 1'b0;
        chk("first_ack_drop", int'(code_valid), 0);

        // Table of back-to-back windows
        auto_ack = 1'b1;
        foreach (vecs[k]) begin
            exp_q.push_back(vecs[k].exp_code);
            drive_window(vecs[k].pat, vecs[k].gap);
            chk("vec_busy", int'(busy), 1);
            chk("vec_conflict", int'(conflict), int'(vecs[k].exp_conf));
        end
        repeat (3) tick();
        chk("sb_drained", exp_q.size(), 0);
        chk("vec_ovr", int'(ovr), 0);
        auto_ack = 1'b0;

        // Overrun: two windows without ack
        drive_window(16'h5555, 0);
        chk("ovr_first_valid", int'(code_valid), 1);
        chk("ovr_before", int'(ovr), 0);
        drive_window(16'hAAAA, 0);
        chk("ovr_code_kept", int'(code), 16);
        chk("ovr_valid", int'(code_valid), 1);
        chk("ovr_set", int'(ovr), 1);

        // Asynchronous reset mid-window
        drive_sample(2'd1, 0);
        drive_sample(2'd2, 0);
        drive_sample(2'd1, 0);
        reset = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        en = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Ack on the cycle a second window completes
        en = 1'b1;
        tick();
        drive_sample(2'd1, 0);
        drive_sample(2'd1, 0);
        drive_window(16'h5555, 0);
        chk("ackcomp_first", int'(code), 16);
        for (int i = 0; i < 7; i++) drive_sample(2'd0, 0);
        manual_ack = 1'b1;
        drive_sample(2'd1, 0);
        manual_ack = 1'b0;
        chk("ackcomp_code", int'(code), 9);
        chk("ackcomp_valid", int'(code_valid), 1);
        chk("ackcomp_ovr", int'(ovr), 0);
        manual_ack = 1'b1;
        tick();
        manual_ack = 1'b0;
        chk("ackcomp_drop", int'(code_valid), 0);

        // en dropped mid-window, then re-enabled: settle repeats, partial discarded
        for (int i = 0; i < 5; i++) drive_sample(2'd1, 0);
        en = 1'b0;
        tick();
        chk("endrop_busy", int'(busy), 0);
        chk("endrop_valid", int'(code_valid), 0);
        repeat (2) tick();
        en = 1'b1;
        tick();
        chk("reen_busy", int'(busy), 1);
        drive_sample(2'd0, 0);
        drive_sample(2'd0, 0);
        for (int i = 0; i < 7; i++) drive_sample(2'd0, 0);
        chk("reen_pre_valid", int'(code_valid), 0);
        drive_sample(2'd0, 0);
        chk("reen_valid", int'(code_valid), 1);
        chk("reen_code", int'(code), 8);
        chk("reen_conflict", int'(conflict), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
